// File: rtl/piano_pkg.sv
// Shared constants, FSM state type and small lookup helpers for the
// free-play note path (key select, map slot lookup, music code arithmetic).
package piano_pkg;

    localparam logic [1:0] MODE_REMAP       = 2'b11;
    localparam logic [4:0] MUSIC_SILENT     = 5'd0;
    localparam logic [2:0] DEG_UNMAPPED     = 3'd7;
    localparam int         NOTES_PER_OCTAVE = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_SUSTAIN = 2'd2
    } state_t;

    // Lowest key index wins; key k lives on bit 7-k of the key set.
    function automatic logic [2:0] pick_key(input logic [7:0] keys);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (keys[7-k]) idx = 3'(k);
        end
        return idx;
    endfunction

    // Slot k of the map is map[3k+2:3k].
    function automatic logic [2:0] slot_deg(input logic [23:0] map, input logic [2:0] idx);
        return map[int'(idx)*3 +: 3];
    endfunction

    // Octave 3 folds onto 2, so the result never exceeds 21.
    function automatic logic [4:0] note_code(input logic [2:0] deg, input logic [1:0] oct);
        logic [1:0] oct_c;
        oct_c = (oct == 2'd3) ? 2'd2 : oct;
        return 5'd1 + {2'b00, deg} + 5'(NOTES_PER_OCTAVE) * {3'b000, oct_c};
    endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchronizer plus debounce for the eight touch keys. The accept
// pulse is combinational and fires in the cycle whose edge moves the stable
// counter to DEBOUNCE_CYCLES-1; key_set is the candidate set at that moment.
module key_sync_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] touch,
    output logic [7:0] key_set,
    output logic       accept
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [7:0]    sync1;
    logic [7:0]    touch_s;
    logic [7:0]    cand;
    logic [CW-1:0] cnt;

    // Synchronize raw keys, track the candidate set and count stable cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            touch_s <= '0;
            cand    <= '0;
            cnt     <= '0;
        end else begin
            sync1   <= touch;
            touch_s <= sync1;
            if (touch_s != cand) begin
                cand <= touch_s;
                cnt  <= '0;
            end else if (clear) begin
                cnt <= '0;
            end else if (cnt != CW'(DEBOUNCE_CYCLES)) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Saturation past DEBOUNCE_CYCLES-1 keeps this to one pulse per stable set.
    assign accept  = !clear && (touch_s == cand) && (cnt == CW'(DEBOUNCE_CYCLES - 2));
    assign key_set = cand;

endmodule

// File: rtl/keymap_player.sv
// Free-play note generator: debounced key set -> priority key -> map lookup
// -> registered music code with a one-cycle note_on pulse.
// Optional feature macro: KEYMAP_PLAYER_SUSTAIN_EN adds a SUSTAIN state that
// holds the last note for SUSTAIN_CYCLES after release.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | silent, waiting for an accepted nonzero key set
// PLAY    | a key set is held; music latched at entry / re-evaluation
// SUSTAIN | keys released, last note held until the down-counter expires
module keymap_player
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int SUSTAIN_CYCLES  = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [7:0]  touch,
    input  logic [23:0] an_jian,
    input  logic [1:0]  octave,
    output logic [4:0]  music,
    output logic [2:0]  key_idx,
    output logic        note_on
);

    if (DEBOUNCE_CYCLES < 2 || SUSTAIN_CYCLES < 1) begin : g_param_check
        $error("keymap_player: DEBOUNCE_CYCLES must be >= 2 and SUSTAIN_CYCLES >= 1");
    end

    state_t      state, state_n;
    logic [4:0]  music_n;
    logic [2:0]  key_idx_n;
    logic        note_on_n;
    logic [7:0]  cur_set, cur_set_n;

    logic [7:0]  key_set;
    logic        accept;
    logic        remap;
    logic [2:0]  sel_key;
    logic [2:0]  sel_deg;
    logic [4:0]  eval_music;

`ifdef KEYMAP_PLAYER_SUSTAIN_EN
    localparam int SW = $clog2(SUSTAIN_CYCLES + 1);
    logic [SW-1:0] sus_cnt, sus_cnt_n;
`endif

    assign remap = (mode == MODE_REMAP);

    key_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .clear  (remap),
        .touch  (touch),
        .key_set(key_set),
        .accept (accept)
    );

    assign sel_key    = pick_key(key_set);
    assign sel_deg    = slot_deg(an_jian, sel_key);
    assign eval_music = (sel_deg == DEG_UNMAPPED) ? MUSIC_SILENT : note_code(sel_deg, octave);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            music   <= MUSIC_SILENT;
            key_idx <= 3'd0;
            note_on <= 1'b0;
            cur_set <= 8'd0;
        end else begin
            state   <= state_n;
            music   <= music_n;
            key_idx <= key_idx_n;
            note_on <= note_on_n;
            cur_set <= cur_set_n;
        end
    end

`ifdef KEYMAP_PLAYER_SUSTAIN_EN
    // Sustain hold-time down-counter.
    always_ff @(posedge clk) begin
        if (reset) sus_cnt <= '0;
        else       sus_cnt <= sus_cnt_n;
    end
`endif

    // Next state and outputs; music is only recomputed on entry/re-evaluation,
    // which is what freezes a sounding note against map or octave edits.
    always_comb begin
        state_n   = state;
        music_n   = music;
        key_idx_n = key_idx;
        note_on_n = 1'b0;
        cur_set_n = cur_set;
`ifdef KEYMAP_PLAYER_SUSTAIN_EN
        sus_cnt_n = sus_cnt;
`endif
        if (remap) begin
            state_n   = ST_IDLE;
            music_n   = MUSIC_SILENT;
            key_idx_n = 3'd0;
            cur_set_n = 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && key_set != 8'd0) begin
                        state_n   = ST_PLAY;
                        music_n   = eval_music;
                        key_idx_n = sel_key;
                        note_on_n = (eval_music != MUSIC_SILENT);
                        cur_set_n = key_set;
                    end
                end
                ST_PLAY: begin
                    if (accept) begin
                        if (key_set == 8'd0) begin
                            cur_set_n = 8'd0;
`ifdef KEYMAP_PLAYER_SUSTAIN_EN
                            state_n   = ST_SUSTAIN;
                            sus_cnt_n = SW'(SUSTAIN_CYCLES - 1);
`else
                            state_n   = ST_IDLE;
                            music_n   = MUSIC_SILENT;
                            key_idx_n = 3'd0;
`endif
                        end else if (key_set != cur_set) begin
                            music_n   = eval_music;
                            key_idx_n = sel_key;
                            note_on_n = (eval_music != MUSIC_SILENT) && (eval_music != music);
                            cur_set_n = key_set;
                        end
                    end
                end
`ifdef KEYMAP_PLAYER_SUSTAIN_EN
                ST_SUSTAIN: begin
                    if (accept && key_set != 8'd0) begin
                        state_n   = ST_PLAY;
                        music_n   = eval_music;
                        key_idx_n = sel_key;
                        note_on_n = (eval_music != MUSIC_SILENT);
                        cur_set_n = key_set;
                    end else if (sus_cnt == '0) begin
                        state_n   = ST_IDLE;
                        music_n   = MUSIC_SILENT;
                        key_idx_n = 3'd0;
                    end else begin
                        sus_cnt_n = sus_cnt - SW'(1);
                    end
                end
`endif
                default: begin
                    state_n   = ST_IDLE;
                    music_n   = MUSIC_SILENT;
                    key_idx_n = 3'd0;
                    cur_set_n = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keymap_player.sv
// Scoreboard bench for keymap_player with DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=8.
// Stimulus pushes hand-computed output events (music, key_idx, note_on, cycle);
// a monitor pops one entry whenever music/key_idx change or note_on is high.
module tb_keymap_player;

    localparam int DEB = 4;
    localparam int SUS = 8;
`ifdef KEYMAP_PLAYER_SUSTAIN_EN
    localparam int REL_LAT = DEB + 2 + SUS;
`else
    localparam int REL_LAT = DEB + 2;
`endif
    localparam int PRESS_LAT = DEB + 2;
    localparam logic [23:0] ID_MAP = 24'b111_110_101_100_011_010_001_000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [7:0]  touch;
    logic [23:0] an_jian;
    logic [1:0]  octave;
    logic [4:0]  music;
    logic [2:0]  key_idx;
    logic        note_on;

    typedef struct {
        logic [4:0] music;
        logic [2:0] key_idx;
        logic       note_on;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [4:0] prev_music = 5'd0;
    logic [2:0] prev_key   = 3'd0;

    keymap_player #(
        .DEBOUNCE_CYCLES(DEB),
        .SUSTAIN_CYCLES (SUS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .touch  (touch),
        .an_jian(an_jian),
        .octave (octave),
        .music  (music),
        .key_idx(key_idx),
        .note_on(note_on)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // lat < 0 means the exact cycle is not checked.
    task automatic push(input logic [4:0] m, input logic [2:0] k, input logic n, input int lat);
        exp_t e;
        e.music   = m;
        e.key_idx = k;
        e.note_on = n;
        e.cyc     = (lat < 0) ? -1 : cyc + lat;
        q.push_back(e);
    endtask

    // Monitor: every output event must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (music !== prev_music || key_idx !== prev_key || note_on !== 1'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d music=%0d key_idx=%0d note_on=%0b",
                             cyc, music, key_idx, note_on);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (music !== e.music || key_idx !== e.key_idx || note_on !== e.note_on ||
                        (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL output_event cyc=%0d got music=%0d key_idx=%0d note_on=%0b, want music=%0d key_idx=%0d note_on=%0b at cyc=%0d",
                                 cyc, music, key_idx, note_on, e.music, e.key_idx, e.note_on, e.cyc);
                    end
                end
            end
            prev_music = music;
            prev_key   = key_idx;
        end
    end

    initial begin
        reset   = 1'b1;
        mode    = 2'b00;
        touch   = 8'd0;
        an_jian = ID_MAP;
        octave  = 2'd0;
        wait_cyc(3);
        checks++;
        if (music !== 5'd0 || key_idx !== 3'd0 || note_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_state music=%0d key_idx=%0d note_on=%0b, want 0 0 0",
                     music, key_idx, note_on);
        end
        prev_music = music;
        prev_key   = key_idx;
        mon_en     = 1'b1;
        reset      = 1'b0;
        wait_cyc(10);

        // Single key: key 2, octave 1 -> 10.
        octave = 2'd1;
        touch  = 8'b0010_0000;
        push(5'd10, 3'd2, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);

        // Bounce: 20 cycles of 2-cycle toggling must never be accepted.
        for (int i = 0; i < 5; i++) begin
            touch = 8'b0000_1000;
            wait_cyc(2);
            touch = 8'd0;
            wait_cyc(2);
        end
        wait_cyc(12);

        // Priority: keys 0 and 7 -> key 0, octave 0 -> 1.
        octave = 2'd0;
        touch  = 8'b1000_0001;
        push(5'd1, 3'd0, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);

        // Unmapped slot 0: silent, key_idx 0, nothing observable.
        an_jian[2:0] = 3'd7;
        touch = 8'b1000_0001;
        wait_cyc(12);
        touch = 8'd0;
        wait_cyc(REL_LAT + 6);

        // Unmapped slot 5: key_idx shows 5 while music stays 0, no note_on.
        an_jian[17:15] = 3'd7;
        touch = 8'b0000_0100;
        push(5'd0, 3'd5, 1'b0, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);
        an_jian = ID_MAP;

        // Remap mid-note: key 3 keeps 4 until re-pressed, then 7.
        touch = 8'b0001_0000;
        push(5'd4, 3'd3, 1'b1, PRESS_LAT);
        wait_cyc(PRESS_LAT + 2);
        an_jian[11:9] = 3'd6;
        octave = 2'd2;
        wait_cyc(10);
        octave = 2'd0;
        touch  = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);
        touch = 8'b0001_0000;
        push(5'd7, 3'd3, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);
        an_jian = ID_MAP;

        // Re-evaluation in PLAY: key 2 -> add key 0 -> add key 7 (same winner).
        touch = 8'b0010_0000;
        push(5'd3, 3'd2, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'b1010_0000;
        push(5'd1, 3'd0, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'b1010_0001;
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);

        // Mode and reset: key 4, octave 3 (clamped to 2) -> 19.
        octave = 2'd3;
        touch  = 8'b0000_1000;
        push(5'd19, 3'd4, 1'b1, PRESS_LAT);
        wait_cyc(10);
        mode = 2'b11;
        push(5'd0, 3'd0, 1'b0, 1);
        wait_cyc(5);
        mode = 2'b00;
        push(5'd19, 3'd4, 1'b1, -1);
        wait_cyc(10);
        reset = 1'b1;
        push(5'd0, 3'd0, 1'b0, 1);
        wait_cyc(1);
        reset = 1'b0;
        push(5'd19, 3'd4, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);

`ifdef KEYMAP_PLAYER_SUSTAIN_EN
        // Sustain: key 1, octave 2 -> 16, held 8 extra cycles after release.
        octave = 2'd2;
        touch  = 8'b0100_0000;
        push(5'd16, 3'd1, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);
        // Re-press during sustain: same code, fresh note_on.
        touch = 8'b0100_0000;
        push(5'd16, 3'd1, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        wait_cyc(PRESS_LAT + 1);
        touch = 8'b0100_0000;
        push(5'd16, 3'd1, 1'b1, PRESS_LAT);
        wait_cyc(10);
        touch = 8'd0;
        push(5'd0, 3'd0, 1'b0, REL_LAT);
        wait_cyc(REL_LAT + 6);
`endif

        wait_cyc(5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events pending=%0d, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keymap_player.md
# keymap_player

Free-play note generator for the piano. It sits directly downstream of the key-remap stage and consumes that stage's 24-bit key-to-degree map. It synchronizes and debounces the eight touch keys, picks one key by priority, and looks the key up in the map. It then emits a registered 5-bit music code for the buzzer/tone stage, along with a one-cycle note-on pulse.

## Interface
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles required to accept a key-set change (20 ms at 100 MHz); minimum 2.
- SUSTAIN_CYCLES, 25_000_000, cycles the last note is held after release. Used only when sustain is compiled in.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  global mode; 2'b11 = remap (block silent), any other value = play.
- touch  in  8  raw asynchronous keys. Bit 7 is key 0 and bit 0 is key 7.
- an_jian  in  24  key map. Slot k is an_jian[3k+2:3k] and holds degree 0..6; value 7 means unmapped.
- octave  in  2  octave select 0..2; 3 is treated as 2.
- music  out  5  0 = silent, otherwise 1 + degree + 7*octave (range 1..21).
- key_idx  out  3  index of the key currently sounding; 0 when silent.
- note_on  out  1  one-cycle pulse on every new music code that is not 0.

## Operation
- Synchronizer: touch passes through 2 flops to produce touch_s. These flops reset to 0.
- Debounce:
  - cand register and a counter. When touch_s differs from cand, cand takes touch_s and the counter clears.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
  - A change is accepted on the cycle the counter reaches DEBOUNCE_CYCLES-1. The "accept" event fires once per stable set.
- Key select: the lowest key index with its bit set wins, so 8'b10000001 selects key 0.
- States:
  - IDLE: music=0. Accepted nonzero set goes to PLAY.
  - PLAY:
    - Accepted nonzero set that differs from the current one: re-evaluate and stay in PLAY. note_on pulses if the resulting music changes.
    - Accepted zero set: go to IDLE, or to SUSTAIN when compiled in.
  - SUSTAIN (only when compiled in): music holds.
    - Accepted nonzero set goes to PLAY.
    - After SUSTAIN_CYCLES, go to IDLE.
- On PLAY entry or re-evaluation:
  - Slot key_idx of an_jian and the clamped octave are latched. Later changes to an_jian or octave do not alter a sounding note.
  - Degree 7 gives music=0, key_idx=selected key, no note_on.
- Arithmetic: music = 5'd1 + {2'b0,deg} + 5'd7*oct. The maximum is 21, so there is no overflow.
- mode==2'b11:
  - Forces IDLE, music=0, key_idx=0, note_on=0 on the next edge.
  - Clears the debounce counter, so a key held across the mode exit must re-debounce.
- Reset: state=IDLE, music=0, key_idx=0, note_on=0, touch_s=0, cand=0, counters=0. Reset takes priority over mode and over any in-flight debounce or sustain.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- A clean touch step applied before edge 0 gives touch_s at edge 2. music and note_on appear at edge DEBOUNCE_CYCLES+2.
- Release to silence takes the same latency. With sustain compiled in, add SUSTAIN_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES cycles on touch_s produce no output change.
- note_on is high for exactly the one cycle in which the new music value first appears.

## Configuration
- KEYMAP_PLAYER_SUSTAIN_EN defined: the SUSTAIN state and its counter are present and SUSTAIN_CYCLES is honoured.
- KEYMAP_PLAYER_SUSTAIN_EN undefined: an accepted zero set goes straight to IDLE, and the SUSTAIN logic and counter are absent.

## Structure
- piano_pkg holds:
  - MODE_REMAP = 2'b11
  - MUSIC_SILENT = 5'd0
  - DEG_UNMAPPED = 3'd7
  - NOTES_PER_OCTAVE = 7
  - the state enum
- One sub-module, key_sync_debounce, contains the synchronizer, cand, the counter and the accept pulse. It outputs the stable set and the accept pulse.

## Test plan
Use DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=8 and the identity map an_jian=24'b111_110_101_100_011_010_001_000 throughout.
- Single key: touch=8'b00100000, octave=1, mode=0. After 6 edges, music=10 and key_idx=2. note_on is high for exactly 1 cycle. Release gives music=0 six edges later (sustain out).
- Bounce: touch toggles 8'b00001000 every 2 cycles for 20 cycles, then settles at 0. music stays 0 and note_on never fires.
- Priority and unmapped slot: touch=8'b10000001 gives music=1 (octave 0) and key_idx=0. Set slot 0 to 7 and retrigger: music=0, no note_on.
- Remap mid-note: while key 3 sounds (music=4), set slot 3 to 3'd6. music stays 4 until release and re-press, then becomes 7.
- Mode and reset: mode=2'b11 during PLAY gives music=0 the next edge. reset=1 for one cycle during PLAY clears all outputs. After release, the held key re-debounces and sounds 6 edges later.
- Sustain (macro defined): release key 1 at octave 2. music=16 holds for 8 extra cycles, then becomes 0. Re-press during sustain returns to PLAY with note_on.
